aes_subshift_stage: RTL and testbench



---
 rtl/aes_pkg.sv | 49 ++++
 rtl/aes_sbox.sv | 25 ++
 rtl/aes_subshift_stage.sv | 165 ++++++++++++++++
 tb/tb_aes_subshift_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, FSM encoding, byte addressing and S-box tables.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_NBYTES  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } aes_fsm_e;

  // Byte b of each table lives at bits [8*(255-b) +: 8].
  localparam logic [2047:0] SBOX_FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // LSB offset of byte (row, col); byte k = 4*col + row sits at bit 8*(15-k).
  function automatic logic [6:0] byte_lsb(input logic [1:0] row, input logic [1:0] col);
    return {~col, ~row, 3'b000};
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV_TBL[{~b, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational byte substitution; AES_INV_EN adds the inverse table and a select.
module aes_sbox
  import aes_pkg::*;
(
`ifdef AES_INV_EN
  input  logic       inv_i,
`endif
  input  logic [7:0] din_i,
  output logic [7:0] dout_c_o
);

`ifdef AES_INV_EN
  logic [7:0] fwd_c;
  logic [7:0] inv_c;

  // Both tables are looked up in parallel; inv_i picks the result.
  assign fwd_c    = sbox_fwd(din_i);
  assign inv_c    = sbox_inv(din_i);
  assign dout_c_o = inv_i ? inv_c : fwd_c;
`else
  // Forward table only.
  assign dout_c_o = sbox_fwd(din_i);
`endif

endmodule

// File: rtl/aes_subshift_stage.sv
// Iterative SubBytes + ShiftRows stage, SBOX_LANES bytes per cycle.
// Optional macro AES_INV_EN adds in_inv/out_inv for InvSubBytes + InvShiftRows.
module aes_subshift_stage
  import aes_pkg::*;
#(
  parameter int unsigned SBOX_LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic                   in_last,
`ifdef AES_INV_EN
  input  logic                   in_inv,
  output logic                   out_inv,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   out_last
);

  localparam int unsigned NBEATS = AES_NBYTES / SBOX_LANES;
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBEATS - 1);

  // Only divisors of 16 give a whole number of beats per block.
  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4 &&
      SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
    $fatal(1, "aes_subshift_stage: SBOX_LANES must be 1, 2, 4, 8 or 16");
  end

  aes_fsm_e               state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] blk_q, blk_d;
  logic [AES_STATE_W-1:0] res_q, res_d;
  logic                   last_q, last_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
`ifdef AES_INV_EN
  logic                   inv_q, inv_d;
  logic                   out_inv_q, out_inv_d;
`endif
  logic                   accept;

  logic [7:0] lane_out  [SBOX_LANES];
  logic [1:0] lane_row  [SBOX_LANES];
  logic [1:0] lane_dcol [SBOX_LANES];

  // Per-lane byte pick, substitution and ShiftRows destination column.
  for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
    logic [3:0] k;
    logic [1:0] col;
    logic [7:0] din;

    assign k           = 4'(32'(cnt_q) * SBOX_LANES + 32'(g));
    assign col         = k[3:2];
    assign lane_row[g] = k[1:0];
    assign din         = blk_q[byte_lsb(k[1:0], col) +: 8];
`ifdef AES_INV_EN
    assign lane_dcol[g] = inv_q ? (col + k[1:0]) : (col - k[1:0]);
    aes_sbox u_sbox (.inv_i(inv_q), .din_i(din), .dout_c_o(lane_out[g]));
`else
    assign lane_dcol[g] = col - k[1:0];
    aes_sbox u_sbox (.din_i(din), .dout_c_o(lane_out[g]));
`endif
  end

  // Next-state, handshake and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    res_d       = res_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef AES_INV_EN
    inv_d       = inv_q;
    out_inv_d   = out_inv_q;
`endif
    in_ready    = 1'b0;

    case (state_q)
      IDLE:    in_ready = rst_n;
      DONE:    in_ready = rst_n & out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;

    if (accept) begin
      blk_d   = in_state;
      last_d  = in_last;
`ifdef AES_INV_EN
      inv_d   = in_inv;
`endif
      cnt_d   = '0;
      state_d = SUB;
    end

    case (state_q)
      IDLE: ;
      SUB: begin
        for (int unsigned l = 0; l < SBOX_LANES; l++) begin
          res_d[byte_lsb(lane_row[l], lane_dcol[l]) +: 8] = lane_out[l];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_last_d  = last_q;
`ifdef AES_INV_EN
          out_inv_d   = inv_q;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!accept) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      blk_q       <= '0;
      res_q       <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef AES_INV_EN
      inv_q       <= 1'b0;
      out_inv_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      res_q       <= res_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef AES_INV_EN
      inv_q       <= inv_d;
      out_inv_q   <= out_inv_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_state = res_q;
  assign out_last  = out_last_q;
`ifdef AES_INV_EN
  assign out_inv   = out_inv_q;
`endif

endmodule

// File: tb/tb_aes_subshift_stage.sv
// Bench for aes_subshift_stage: directed FIPS vectors, backpressure, reset, random blocks, lane sweep.
module tb_aes_subshift_stage;

  localparam int unsigned NB     = 4;
  localparam int unsigned NBEATS = 16 / NB;
  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [127:0] in_state, out_state;
`ifdef AES_INV_EN
  logic         in_inv, out_inv;
  logic [4:0]   sw_out_inv;
`endif
  logic         sw_valid;
  logic [127:0] sw_state;
  logic [4:0]   sw_in_ready, sw_out_valid, sw_out_last;
  logic [127:0] sw_out_state [5];

  int checks = 0;
  int errors = 0;
  logic [7:0] fsb [256];
  logic [7:0] isb [256];
  logic       cur_inv;

  aes_subshift_stage #(.SBOX_LANES(NB)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_last   (in_last),
`ifdef AES_INV_EN
    .in_inv    (in_inv),
    .out_inv   (out_inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_last  (out_last)
  );

  for (genvar g = 0; g < 5; g++) begin : g_sweep
    aes_subshift_stage #(.SBOX_LANES(32'd1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sw_valid),
      .in_ready  (sw_in_ready[g]),
      .in_state  (sw_state),
      .in_last   (1'b0),
`ifdef AES_INV_EN
      .in_inv    (1'b0),
      .out_inv   (sw_out_inv[g]),
`endif
      .out_valid (sw_out_valid[g]),
      .out_ready (1'b1),
      .out_state (sw_out_state[g]),
      .out_last  (sw_out_last[g])
    );
  end

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_tables();
    logic [7:0] iv, s;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
      fsb[x] = s;
    end
    for (int x = 0; x < 256; x++) isb[fsb[x]] = 8'(x);
  endtask

  // Reference: substitute every byte, then rotate row r left (fwd) or right (inv) by r.
  function automatic logic [127:0] ref_out(input logic [127:0] st, input logic inv);
    logic [127:0] o;
    logic [7:0]   b;
    int r, c, dc;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      r  = k % 4;
      c  = k / 4;
      dc = inv ? (c + r) % 4 : (c - r + 4) % 4;
      b  = st[127 - 8 * k -: 8];
      o[127 - 8 * (4 * dc + r) -: 8] = inv ? isb[b] : fsb[b];
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk_v(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Offer a block, wait for acceptance, then count cycles (acceptance cycle = 0) until out_valid.
  task automatic send_blk(input logic [127:0] st, input logic last,
                          output logic [127:0] got, output int cyc);
    int n;
    @(negedge clk);
    in_state = st;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk_b("accept_ready", in_ready, 1'b1);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      if (cyc == 0) begin
        in_valid = 1'b0;
        in_state = rnd128();
        in_last  = ~last;
      end
      cyc++;
    end while (!out_valid && cyc < 64);
    got = out_state;
  endtask

  initial begin
    logic [127:0] got, a, b, c, d, s;
    logic [127:0] sw_got [5];
    int           sw_lat [5];
    int           cyc;
    logic         l;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    sw_valid  = 1'b0;
    sw_state  = '0;
    cur_inv   = 1'b0;
`ifdef AES_INV_EN
    in_inv    = 1'b0;
`endif
    build_tables();

    // Reset values.
    #12;
    chk_b("rst_in_ready", in_ready, 1'b0);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_v("rst_out_state", out_state, '0);
    chk_b("rst_out_last", out_last, 1'b0);
`ifdef AES_INV_EN
    chk_b("rst_out_inv", out_inv, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_b("idle_in_ready", in_ready, 1'b1);

    // FIPS-197 round 1.
    send_blk(FIPS_IN, 1'b0, got, cyc);
    chk_v("fips_state", got, FIPS_OUT);
    chk_i("fips_latency", cyc, NBEATS + 1);
    chk_b("fips_last", out_last, 1'b0);

    // All-zero state, last-round flag; accepted back-to-back.
    send_blk('0, 1'b1, got, cyc);
    chk_v("zero_state", got, {16{8'h63}});
    chk_b("zero_last", out_last, 1'b1);
    chk_i("zero_latency", cyc, NBEATS + 1);

    // Backpressure: hold result for 10 cycles while a second block waits.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    a = rnd128();
    send_blk(a, 1'b1, got, cyc);
    b = rnd128();
    in_state = b;
    in_last  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_b("stall_valid", out_valid, 1'b1);
      chk_v("stall_state", out_state, ref_out(a, 1'b0));
      chk_b("stall_in_ready", in_ready, 1'b0);
    end
    chk_b("stall_last", out_last, 1'b1);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk_b("handoff_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = rnd128();
    chk_b("handoff_drop", out_valid, 1'b0);
    chk_b("handoff_sub_ready", in_ready, 1'b0);
    cyc = 1;
    while (!out_valid && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk_i("handoff_latency", cyc, NBEATS + 1);
    chk_v("handoff_state", out_state, ref_out(b, 1'b0));
    chk_b("handoff_last", out_last, 1'b0);

    // Reset asserted while cnt == 2.
    @(posedge clk);
    #1;
    c = rnd128();
    @(negedge clk);
    in_state = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_b("midrst_valid", out_valid, 1'b0);
    chk_v("midrst_state", out_state, '0);
    chk_b("midrst_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_v("postrst_state", out_state, '0);
    d = rnd128();
    send_blk(d, 1'b0, got, cyc);
    chk_v("postrst_block", got, ref_out(d, 1'b0));
    chk_i("postrst_latency", cyc, NBEATS + 1);

    // Random blocks against the reference model.
    for (int i = 0; i < 12; i++) begin
      s = rnd128();
      l = 1'($urandom_range(0, 1));
`ifdef AES_INV_EN
      cur_inv = 1'($urandom_range(0, 1));
      in_inv  = cur_inv;
`endif
      send_blk(s, l, got, cyc);
      chk_v($sformatf("rand%0d_state", i), got, ref_out(s, cur_inv));
      chk_b($sformatf("rand%0d_last", i), out_last, l);
      chk_i($sformatf("rand%0d_latency", i), cyc, NBEATS + 1);
`ifdef AES_INV_EN
      chk_b($sformatf("rand%0d_inv", i), out_inv, cur_inv);
`endif
    end

`ifdef AES_INV_EN
    // Inverse direction undoes the FIPS round-1 step.
    cur_inv = 1'b1;
    in_inv  = 1'b1;
    send_blk(FIPS_OUT, 1'b0, got, cyc);
    chk_v("inv_fips_state", got, FIPS_IN);
    chk_b("inv_fips_flag", out_inv, 1'b1);
    in_inv  = 1'b0;
    cur_inv = 1'b0;
`endif

    // Lane sweep on the FIPS vector.
    @(posedge clk);
    #1;
    sw_state = FIPS_IN;
    for (int g = 0; g < 5; g++) begin
      sw_lat[g] = 0;
      sw_got[g] = '0;
    end
    @(negedge clk);
    sw_valid = 1'b1;
    for (int g = 0; g < 5; g++) chk_b($sformatf("sweep%0d_ready", g), sw_in_ready[g], 1'b1);
    @(posedge clk);
    #1;
    sw_valid = 1'b0;
    sw_state = rnd128();
    for (int cy = 1; cy <= 24; cy++) begin
      for (int g = 0; g < 5; g++) begin
        if (sw_out_valid[g] && sw_lat[g] == 0) begin
          sw_lat[g] = cy;
          sw_got[g] = sw_out_state[g];
        end
      end
      @(posedge clk);
      #1;
    end
    for (int g = 0; g < 5; g++) begin
      chk_i($sformatf("sweep%0d_latency", g), sw_lat[g], (16 >> g) + 1);
      chk_v($sformatf("sweep%0d_state", g), sw_got[g], FIPS_OUT);
      chk_b($sformatf("sweep%0d_last", g), sw_out_last[g], 1'b0);
`ifdef AES_INV_EN
      chk_b($sformatf("sweep%0d_inv", g), sw_out_inv[g], 1'b0);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
